// File: rtl/ncw_hazard_ctrl_pkg.sv
// Shared constants and types for the NCW-load hazard controller and the datapath
// write-address mux (opcode defines, redirect window, shadow record type).
package ncw_hazard_ctrl_pkg;

    localparam logic [5:0] OpLw   = 6'h23;
    localparam logic [5:0] OpSw   = 6'h2b;
    localparam logic [5:0] OpLwld = 6'h37;

    localparam logic [31:0] NCW_ADDR_LO  = 32'h0000_3000;
    localparam logic [31:0] NCW_ADDR_HI  = 32'h0000_4ffc;
    localparam logic [4:0]  NCW_LINK_REG = 5'd31;

    // One pipeline-stage shadow of an NCW load; addr is rt in E/M and the resolved wa in W.
    typedef struct packed {
        logic       valid;
        logic [4:0] addr;
    } ncw_rec_t;

endpackage

// File: rtl/ncw_resolve.sv
// Combinational destination resolution for an NCW load: the link register when the
// loaded word is an aligned value inside [ADDR_LO, ADDR_HI], otherwise rt.
module ncw_resolve
    import ncw_hazard_ctrl_pkg::*;
#(
    parameter logic [31:0] ADDR_LO  = NCW_ADDR_LO,
    parameter logic [31:0] ADDR_HI  = NCW_ADDR_HI,
    parameter logic [4:0]  LINK_REG = NCW_LINK_REG
) (
    input  logic [4:0]  rt,
    input  logic [31:0] memdata,
    output logic [4:0]  wa
);

    logic w_in_range;

    assign w_in_range = (memdata >= ADDR_LO) && (memdata <= ADDR_HI) && (memdata[1:0] == 2'b00);
    assign wa         = w_in_range ? LINK_REG : rt;

endmodule

// File: rtl/ncw_hazard_ctrl.sv
// Shadows NCW loads through E/M/W, stalls D on a possibly-unresolved destination and
// resolves the real write address in M. Optional stall counter: NCW_STALL_CNT_EN.
module ncw_hazard_ctrl
    import ncw_hazard_ctrl_pkg::*;
#(
    parameter logic [31:0] ADDR_LO  = NCW_ADDR_LO,
    parameter logic [31:0] ADDR_HI  = NCW_ADDR_HI,
    parameter logic [4:0]  LINK_REG = NCW_LINK_REG
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        d_valid,
    input  logic        d_ncw,
    input  logic [4:0]  d_rt,
    input  logic        d_rs_use,
    input  logic        d_rt_use,
    input  logic [4:0]  d_rs,
    input  logic        ext_stall,
    input  logic        e_flush,
    input  logic [31:0] m_memdata,
    output logic        stall,
    output logic        w_ncw,
    output logic [4:0]  w_wa,
    output logic [31:0] stall_cnt
);

    ncw_rec_t   r_e;
    ncw_rec_t   r_m;
    ncw_rec_t   r_w;
    logic [4:0] w_m_wa;

    // Either in-flight record may still redirect to LINK_REG, so it always counts as a hit.
    function automatic logic hit(input logic [4:0] r, input ncw_rec_t e, input ncw_rec_t m);
        return (e.valid && (r == e.addr || r == LINK_REG)) ||
               (m.valid && (r == m.addr || r == LINK_REG));
    endfunction

    ncw_resolve #(
        .ADDR_LO  (ADDR_LO),
        .ADDR_HI  (ADDR_HI),
        .LINK_REG (LINK_REG)
    ) u_resolve (
        .rt      (r_m.addr),
        .memdata (m_memdata),
        .wa      (w_m_wa)
    );

    always_comb begin
        stall = d_valid &&
                ((d_rs_use && d_rs != 5'd0 && hit(d_rs, r_e, r_m)) ||
                 (d_rt_use && d_rt != 5'd0 && hit(d_rt, r_e, r_m)));
    end

    // NOTE: state registers use non-blocking assignments so E->M->W all shift on the old values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_e <= '0;
            r_m <= '0;
            r_w <= '0;
        end else begin
            if (stall || ext_stall || e_flush) begin
                r_e <= '0;
            end else begin
                r_e <= '{valid: d_valid && d_ncw, addr: d_rt};
            end
            r_m <= r_e;
            r_w <= '{valid: r_m.valid, addr: w_m_wa};
        end
    end

    assign w_ncw = r_w.valid;
    assign w_wa  = r_w.addr;

`ifdef NCW_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (stall && r_stall_cnt != 32'hFFFF_FFFF) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`else
    assign stall_cnt = 32'd0;
`endif

endmodule
